// File: rtl/fcmp_pipe_if.sv
// Handshake/operand bundle for fcmp_pipe: issue side (x1/x2/op/tag) and result side (y/tag).
// The invalid-flag signals exist only when FCMP_NV_FLAG_EN is defined.
interface fcmp_pipe_if #(
    parameter int EXP_W = 8,
    parameter int MAN_W = 23,
    parameter int TAG_W = 5
);
    localparam int W = 1 + EXP_W + MAN_W;

    logic             in_valid;
    logic             in_ready;
    logic [W-1:0]     x1;
    logic [W-1:0]     x2;
    logic [1:0]       op;
    logic [TAG_W-1:0] in_tag;
    logic             out_valid;
    logic             out_ready;
    logic             y;
    logic [TAG_W-1:0] out_tag;
`ifdef FCMP_NV_FLAG_EN
    logic             out_nv;
    logic             nv_sticky;
    logic             nv_clr;

    modport master (
        output in_valid, x1, x2, op, in_tag, out_ready, nv_clr,
        input  in_ready, out_valid, y, out_tag, out_nv, nv_sticky
    );
    modport slave (
        input  in_valid, x1, x2, op, in_tag, out_ready, nv_clr,
        output in_ready, out_valid, y, out_tag, out_nv, nv_sticky
    );
`else
    modport master (
        output in_valid, x1, x2, op, in_tag, out_ready,
        input  in_ready, out_valid, y, out_tag
    );
    modport slave (
        input  in_valid, x1, x2, op, in_tag, out_ready,
        output in_ready, out_valid, y, out_tag
    );
`endif
endinterface

// File: rtl/fcmp_pipe.sv
// fcmp_pipe: pipelined IEEE-754 FEQ/FLT/FLE/FUN compare, LATENCY valid/ready stages with bubble collapse.
// Define FCMP_NV_FLAG_EN to add the per-result invalid flag (out_nv) and nv_sticky/nv_clr.
module fcmp_pipe #(
    parameter int EXP_W   = 8,
    parameter int MAN_W   = 23,
    parameter int LATENCY = 2,
    parameter int TAG_W   = 5
) (
    input  logic       clk,
    input  logic       rstn,
    fcmp_pipe_if.slave bus
);
    localparam int W = 1 + EXP_W + MAN_W;
    localparam logic [1:0] OP_FEQ = 2'b00;
    localparam logic [1:0] OP_FLT = 2'b01;
    localparam logic [1:0] OP_FLE = 2'b10;

    logic             sgn1, sgn2;
    logic [EXP_W-1:0] exp1, exp2;
    logic [MAN_W-1:0] man1, man2;
    logic [W-2:0]     mag1, mag2;
    logic             nan1, nan2, snan1, snan2;
    logic             any_nan, any_snan;
    logic             both_zero, mag_lt, mag_gt, mag_eq;
    logic             ord_eq, ord_lt;
    logic             res_y;

    assign {sgn1, exp1, man1} = bus.x1;
    assign {sgn2, exp2, man2} = bus.x2;
    assign mag1 = bus.x1[W-2:0];
    assign mag2 = bus.x2[W-2:0];

    assign nan1     = (&exp1) && (|man1);
    assign nan2     = (&exp2) && (|man2);
    assign snan1    = nan1 && !man1[MAN_W-1];
    assign snan2    = nan2 && !man2[MAN_W-1];
    assign any_nan  = nan1 || nan2;
    assign any_snan = snan1 || snan2;

    // Sign-magnitude order; the two zeros collapse to one point.
    assign both_zero = (mag1 == '0) && (mag2 == '0);
    assign mag_lt    = mag1 < mag2;
    assign mag_gt    = mag1 > mag2;
    assign mag_eq    = mag1 == mag2;
    assign ord_eq    = both_zero || ((sgn1 == sgn2) && mag_eq);
    assign ord_lt    = !both_zero &&
                       ((sgn1 && !sgn2) ||
                        (!sgn1 && !sgn2 && mag_lt) ||
                        (sgn1 && sgn2 && mag_gt));

    always_comb begin
        res_y = 1'b0;
        case (bus.op)
            OP_FEQ:  res_y = !any_nan && ord_eq;
            OP_FLT:  res_y = !any_nan && ord_lt;
            OP_FLE:  res_y = !any_nan && (ord_lt || ord_eq);
            default: res_y = any_nan;
        endcase
    end

    logic [LATENCY-1:0]            valid_q, valid_d;
    logic [LATENCY-1:0]            y_q, y_d;
    logic [LATENCY-1:0][TAG_W-1:0] tag_q, tag_d;
    logic [LATENCY-1:0]            load;

    // A stage loads when it is empty or its successor drains it this edge.
    always_comb begin
        load = '0;
        load[LATENCY-1] = !valid_q[LATENCY-1] || bus.out_ready;
        for (int k = LATENCY - 2; k >= 0; k--) begin
            load[k] = !valid_q[k] || load[k+1];
        end
    end

`ifdef FCMP_NV_FLAG_EN
    logic               res_nv;
    logic [LATENCY-1:0] nv_q, nv_d;
    logic               nv_sticky_q, nv_sticky_d;

    assign res_nv = ((bus.op == OP_FLT) || (bus.op == OP_FLE)) ? any_nan : any_snan;
`endif

    generate
        for (genvar gi = 0; gi < LATENCY; gi++) begin : g_stage
            logic             src_valid;
            logic             src_y;
            logic [TAG_W-1:0] src_tag;
`ifdef FCMP_NV_FLAG_EN
            logic             src_nv;
`endif
            if (gi == 0) begin : g_head
                assign src_valid = bus.in_valid;
                assign src_y     = res_y;
                assign src_tag   = bus.in_tag;
`ifdef FCMP_NV_FLAG_EN
                assign src_nv    = res_nv;
`endif
            end else begin : g_body
                assign src_valid = valid_q[gi-1];
                assign src_y     = y_q[gi-1];
                assign src_tag   = tag_q[gi-1];
`ifdef FCMP_NV_FLAG_EN
                assign src_nv    = nv_q[gi-1];
`endif
            end

            // Payload only moves with a real entry, so a bubble never disturbs held values.
            assign valid_d[gi] = load[gi] ? src_valid : valid_q[gi];
            assign y_d[gi]     = (load[gi] && src_valid) ? src_y : y_q[gi];
            assign tag_d[gi]   = (load[gi] && src_valid) ? src_tag : tag_q[gi];
`ifdef FCMP_NV_FLAG_EN
            assign nv_d[gi]    = (load[gi] && src_valid) ? src_nv : nv_q[gi];
`endif
        end
    endgenerate

    always_ff @(posedge clk) begin
        if (!rstn) begin
            valid_q <= '0;
            y_q     <= '0;
            tag_q   <= '0;
        end else begin
            valid_q <= valid_d;
            y_q     <= y_d;
            tag_q   <= tag_d;
        end
    end

    assign bus.in_ready  = load[0];
    assign bus.out_valid = valid_q[LATENCY-1];
    assign bus.y         = y_q[LATENCY-1];
    assign bus.out_tag   = tag_q[LATENCY-1];

`ifdef FCMP_NV_FLAG_EN
    // A flagged result leaving the unit beats a simultaneous clear.
    assign nv_sticky_d = (valid_q[LATENCY-1] && bus.out_ready && nv_q[LATENCY-1]) ? 1'b1 :
                         (bus.nv_clr ? 1'b0 : nv_sticky_q);

    always_ff @(posedge clk) begin
        if (!rstn) begin
            nv_q        <= '0;
            nv_sticky_q <= 1'b0;
        end else begin
            nv_q        <= nv_d;
            nv_sticky_q <= nv_sticky_d;
        end
    end

    assign bus.out_nv    = nv_q[LATENCY-1];
    assign bus.nv_sticky = nv_sticky_q;
`endif
endmodule

// File: tb/tb_fcmp_pipe.sv
// Bench for fcmp_pipe: LATENCY=2 and LATENCY=3 instances checked against an ordinal-key compare model.
// Covers zeros, NaNs, Inf, denormals, backpressure, mid-stall reset and (with FCMP_NV_FLAG_EN) nv flags.
module tb_fcmp_pipe;
    localparam logic [1:0] FEQ = 2'b00;
    localparam logic [1:0] FLT = 2'b01;
    localparam logic [1:0] FLE = 2'b10;
    localparam logic [1:0] FUN = 2'b11;

    typedef struct packed {
        logic       y;
        logic       nv;
        logic [4:0] tag;
    } exp_t;

    typedef struct packed {
        logic [31:0] a;
        logic [31:0] b;
        logic [1:0]  op;
        logic        y;
    } vec_t;

    localparam int NDIR = 21;
    localparam vec_t DIR [NDIR] = '{
        '{32'h00000000, 32'h80000000, FEQ, 1'b1},
        '{32'h00000000, 32'h80000000, FLT, 1'b0},
        '{32'h00000000, 32'h80000000, FLE, 1'b1},
        '{32'hBF800000, 32'h3F800000, FLT, 1'b1},
        '{32'h3F800000, 32'hBF800000, FLT, 1'b0},
        '{32'h7FC00000, 32'h7FC00000, FEQ, 1'b0},
        '{32'h7FC00000, 32'h7FC00000, FLT, 1'b0},
        '{32'h7FC00000, 32'h7FC00000, FUN, 1'b1},
        '{32'h7F800000, 32'h7F7FFFFF, FLT, 1'b0},
        '{32'h7F7FFFFF, 32'h7F800000, FLE, 1'b1},
        '{32'h00000001, 32'h00000002, FLT, 1'b1},
        '{32'h80000001, 32'h80000002, FLT, 1'b0},
        '{32'h80000002, 32'h80000001, FLT, 1'b1},
        '{32'hFF800000, 32'h80000000, FLT, 1'b1},
        '{32'h3F800000, 32'h40000000, FUN, 1'b0},
        '{32'h80000000, 32'h00000000, FLE, 1'b1},
        '{32'hFF800000, 32'hFF800000, FEQ, 1'b1},
        '{32'h7F800001, 32'h3F800000, FUN, 1'b1},
        '{32'h3F800000, 32'h3F800000, FLE, 1'b1},
        '{32'h40490FDB, 32'h40490FDA, FLE, 1'b0},
        '{32'h7F800001, 32'h7F800001, FEQ, 1'b0}
    };

    localparam vec_t BP [5] = '{
        '{32'h3F800000, 32'h40000000, FLT, 1'b1},
        '{32'h40000000, 32'h3F800000, FLT, 1'b0},
        '{32'hC0000000, 32'hBF800000, FLE, 1'b1},
        '{32'h7F800000, 32'h7F800000, FEQ, 1'b1},
        '{32'h00800000, 32'h007FFFFF, FLT, 1'b0}
    };

    logic clk = 1'b0;
    logic rstn = 1'b0;
    always #5 clk = ~clk;

    fcmp_pipe_if #(.EXP_W(8), .MAN_W(23), .TAG_W(5)) b2 ();
    fcmp_pipe_if #(.EXP_W(8), .MAN_W(23), .TAG_W(5)) b3 ();

    fcmp_pipe #(.EXP_W(8), .MAN_W(23), .LATENCY(2), .TAG_W(5)) u2 (
        .clk (clk),
        .rstn(rstn),
        .bus (b2)
    );
    fcmp_pipe #(.EXP_W(8), .MAN_W(23), .LATENCY(3), .TAG_W(5)) u3 (
        .clk (clk),
        .rstn(rstn),
        .bus (b3)
    );

    int   n_vec = 0;
    int   n_bad = 0;
    int   cyc = 0;
    exp_t sb [2][$];
    logic sticky_exp [2];
    int   log_cyc [$];
    int   log_tag [$];

    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(string nm, logic [31:0] act, logic [31:0] expv);
        n_vec++;
        if (act !== expv) begin
            n_bad++;
            $display("FAIL %s: got %0h, expected %0h (t=%0t)", nm, act, expv, $time);
        end
    endtask

    // Reference: map each non-NaN operand to a signed integer key (both zeros -> 0) and compare keys.
    function automatic exp_t model(logic [31:0] a, logic [31:0] b, logic [1:0] op, logic [4:0] tag);
        exp_t   r;
        logic   na, nb, sna, snb;
        longint ka, kb;
        na  = (a[30:23] == 8'hFF) && (a[22:0] != 23'd0);
        nb  = (b[30:23] == 8'hFF) && (b[22:0] != 23'd0);
        sna = na && !a[22];
        snb = nb && !b[22];
        ka  = a[31] ? -longint'(a[30:0]) : longint'(a[30:0]);
        kb  = b[31] ? -longint'(b[30:0]) : longint'(b[30:0]);
        r.tag = tag;
        case (op)
            FEQ:     begin r.y = !(na || nb) && (ka == kb); r.nv = sna || snb; end
            FLT:     begin r.y = !(na || nb) && (ka < kb);  r.nv = na || nb;   end
            FLE:     begin r.y = !(na || nb) && (ka <= kb); r.nv = na || nb;   end
            default: begin r.y = na || nb;                  r.nv = sna || snb; end
        endcase
        return r;
    endfunction

    always @(negedge clk) begin
        logic       ov [2], ordy [2], oy [2], iv [2], ir [2], clr [2], ost [2], onv [2];
        logic [4:0] otag [2], itag [2];
        logic [31:0] ia [2], ib [2];
        logic [1:0] iop [2];
        exp_t       e;
        ov[0] = b2.out_valid; ordy[0] = b2.out_ready; oy[0] = b2.y; otag[0] = b2.out_tag;
        iv[0] = b2.in_valid;  ir[0] = b2.in_ready;    ia[0] = b2.x1; ib[0] = b2.x2;
        iop[0] = b2.op;       itag[0] = b2.in_tag;
        ov[1] = b3.out_valid; ordy[1] = b3.out_ready; oy[1] = b3.y; otag[1] = b3.out_tag;
        iv[1] = b3.in_valid;  ir[1] = b3.in_ready;    ia[1] = b3.x1; ib[1] = b3.x2;
        iop[1] = b3.op;       itag[1] = b3.in_tag;
`ifdef FCMP_NV_FLAG_EN
        clr[0] = b2.nv_clr; ost[0] = b2.nv_sticky; onv[0] = b2.out_nv;
        clr[1] = b3.nv_clr; ost[1] = b3.nv_sticky; onv[1] = b3.out_nv;
`else
        clr[0] = 1'b0; ost[0] = 1'b0; onv[0] = 1'b0;
        clr[1] = 1'b0; ost[1] = 1'b0; onv[1] = 1'b0;
`endif
        for (int d = 0; d < 2; d++) begin
            if (!rstn) begin
                sb[d].delete();
                sticky_exp[d] = 1'b0;
            end else begin
`ifdef FCMP_NV_FLAG_EN
                chk("nv_sticky", ost[d], sticky_exp[d]);
                if (clr[d]) sticky_exp[d] = 1'b0;
`endif
                if (ov[d]) begin
                    if (sb[d].size() == 0) begin
                        chk("spurious_out_valid", 1, 0);
                    end else begin
                        e = sb[d][0];
                        chk("y", oy[d], e.y);
                        chk("out_tag", otag[d], e.tag);
`ifdef FCMP_NV_FLAG_EN
                        chk("out_nv", onv[d], e.nv);
`endif
                        if (ordy[d]) begin
                            $display("[%0t] u%0d result tag=%0d y=%0b", $time, d, otag[d], oy[d]);
                            if (e.nv) sticky_exp[d] = 1'b1;
                            if (d == 1) begin
                                log_cyc.push_back(cyc);
                                log_tag.push_back(int'(e.tag));
                            end
                            void'(sb[d].pop_front());
                        end
                    end
                end
                if (iv[d] && ir[d]) sb[d].push_back(model(ia[d], ib[d], iop[d], itag[d]));
            end
        end
    end

    task automatic drive(int d, logic v, logic [31:0] a, logic [31:0] b, logic [1:0] op, logic [4:0] tag);
        if (d == 0) begin
            b2.in_valid = v; b2.x1 = a; b2.x2 = b; b2.op = op; b2.in_tag = tag;
        end else begin
            b3.in_valid = v; b3.x1 = a; b3.x2 = b; b3.op = op; b3.in_tag = tag;
        end
    endtask

    task automatic idle(int d);
        if (d == 0) b2.in_valid = 1'b0;
        else        b3.in_valid = 1'b0;
    endtask

    // Offer one operation and return 2 time units after the edge that accepted it.
    task automatic send(int d, logic [31:0] a, logic [31:0] b, logic [1:0] op, logic [4:0] tag, int lit);
        bit   ok = 1'b0;
        exp_t m;
        m = model(a, b, op, tag);
        if (lit >= 0) chk("model_pin", m.y, (lit != 0) ? 1 : 0);
        drive(d, 1'b1, a, b, op, tag);
        for (int i = 0; i < 50 && !ok; i++) begin
            @(negedge clk);
            ok = (d == 0) ? b2.in_ready : b3.in_ready;
            @(posedge clk); #2;
        end
        if (!ok) chk("accept_timeout", 0, 1);
    endtask

    task automatic drain(int d);
        bit done = 1'b0;
        for (int i = 0; i < 100 && !done; i++) begin
            @(posedge clk); #2;
            done = (sb[d].size() == 0);
        end
        if (!done) chk("drain_timeout", 0, 1);
    endtask

    initial begin
        int t;
        drive(0, 1'b0, 32'h0, 32'h0, FEQ, 5'd0);
        drive(1, 1'b0, 32'h0, 32'h0, FEQ, 5'd0);
        b2.out_ready = 1'b1;
        b3.out_ready = 1'b1;
`ifdef FCMP_NV_FLAG_EN
        b2.nv_clr = 1'b0;
        b3.nv_clr = 1'b0;
`endif
        rstn = 1'b0;
        repeat (3) @(posedge clk);
        #2 rstn = 1'b1;

        @(negedge clk);
        chk("rst_out_valid2", b2.out_valid, 0);
        chk("rst_y2", b2.y, 0);
        chk("rst_tag2", b2.out_tag, 0);
        chk("rst_in_ready2", b2.in_ready, 1);
        chk("rst_out_valid3", b3.out_valid, 0);
        chk("rst_in_ready3", b3.in_ready, 1);
        @(posedge clk); #2;

        // Unstalled latency on the LATENCY=2 unit.
        send(0, 32'h3F800000, 32'h3F800000, FEQ, 5'd3, 1);
        idle(0);
        @(negedge clk);
        chk("lat_cycle1_out_valid", b2.out_valid, 0);
        @(negedge clk);
        chk("lat_cycle2_out_valid", b2.out_valid, 1);
        chk("lat_y", b2.y, 1);
        chk("lat_tag", b2.out_tag, 3);
        @(posedge clk); #2;

        for (int i = 0; i < NDIR; i++) begin
            send(0, DIR[i].a, DIR[i].b, DIR[i].op, 5'(i + 10), int'(DIR[i].y));
        end
        idle(0);
        drain(0);

`ifdef FCMP_NV_FLAG_EN
        send(0, 32'h7F800001, 32'h3F800000, FEQ, 5'd7, 0);
        idle(0);
        drain(0);
        chk("sticky_after_snan", b2.nv_sticky, 1);
        b2.nv_clr = 1'b1;
        @(posedge clk); #2;
        chk("sticky_cleared", b2.nv_sticky, 0);
        send(0, 32'h7FC00000, 32'h7FC00000, FLT, 5'd9, 0);
        idle(0);
        t = 0;
        for (int i = 0; i < 20 && t == 0; i++) begin
            @(negedge clk);
            if (b2.out_valid) t = 1;
            @(posedge clk); #2;
        end
        chk("nv_result_seen", t, 1);
        b2.nv_clr = 1'b0;
        chk("sticky_set_beats_clr", b2.nv_sticky, 1);
        @(posedge clk); #2;
`endif

        // Backpressure on the LATENCY=3 unit: only three entries fit.
        log_cyc.delete();
        log_tag.delete();
        b3.out_ready = 1'b0;
        t = 0;
        for (int c = 0; c < 6; c++) begin
            drive(1, 1'b1, BP[t].a, BP[t].b, BP[t].op, 5'(t + 1));
            @(negedge clk);
            if (b3.in_ready && t < 4) t++;
            @(posedge clk); #2;
        end
        chk("bp_accepted", t, 3);
        @(negedge clk);
        chk("bp_in_ready_full", b3.in_ready, 0);
        @(posedge clk); #2;
        b3.out_ready = 1'b1;
        send(1, BP[3].a, BP[3].b, BP[3].op, 5'd4, int'(BP[3].y));
        send(1, BP[4].a, BP[4].b, BP[4].op, 5'd5, int'(BP[4].y));
        idle(1);
        drain(1);
        chk("bp_out_count", log_tag.size(), 5);
        for (int i = 0; i < 5 && i < log_tag.size(); i++) begin
            chk("bp_order", log_tag[i], i + 1);
            chk("bp_back_to_back", log_cyc[i] - log_cyc[0], i);
        end

        // Reset while three entries are stalled.
        b3.out_ready = 1'b0;
        send(1, 32'h7F800001, 32'h3F800000, FEQ, 5'd6, 0);
        send(1, 32'h3F800000, 32'h40000000, FLT, 5'd7, 1);
        send(1, 32'h40000000, 32'h40000000, FLE, 5'd8, 1);
        drive(1, 1'b1, 32'h0, 32'h0, FEQ, 5'd9);
        @(negedge clk);
        chk("stall_in_ready", b3.in_ready, 0);
        chk("stall_out_valid", b3.out_valid, 1);
        @(posedge clk); #2;
        rstn = 1'b0;
        idle(1);
        @(posedge clk); #2;
        rstn = 1'b1;
        @(negedge clk);
        chk("mid_rst_out_valid", b3.out_valid, 0);
        chk("mid_rst_in_ready", b3.in_ready, 1);
        chk("mid_rst_y", b3.y, 0);
        chk("mid_rst_tag", b3.out_tag, 0);
`ifdef FCMP_NV_FLAG_EN
        chk("mid_rst_sticky2", b2.nv_sticky, 0);
        chk("mid_rst_sticky3", b3.nv_sticky, 0);
        chk("mid_rst_out_nv", b3.out_nv, 0);
`endif
        @(posedge clk); #2;

        // Both units resume normally after reset.
        b3.out_ready = 1'b1;
        send(1, 32'hBF800000, 32'h3F800000, FLE, 5'd21, 1);
        send(0, 32'h00000002, 32'h00000001, FLT, 5'd22, 0);
        idle(0);
        idle(1);
        drain(1);
        drain(0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end
endmodule
